// File: rtl/majority_pkg.sv
// Shared helpers and reset/flush constants for the windowed majority voter.
package majority_pkg;

    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // Ones-counter over a 32-bit vector; narrower vectors are zero-extended by the caller.
    function automatic int unsigned popcount(input logic [31:0] bits);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            n += {31'd0, bits[i]};
        end
        return n;
    endfunction

    localparam logic RstInReady  = 1'b1;
    localparam logic ClrInReady  = 1'b0;
    localparam logic RstVote     = 1'b0;
    localparam logic RstVoteAll  = 1'b0;
    localparam logic RstOutValid = 1'b0;
    localparam logic RstWinFull  = 1'b0;

endpackage

// File: rtl/majority_window_ch.sv
// One channel: WIN-deep sample history, running ones count and hysteretic vote flop.
module majority_window_ch
    import majority_pkg::*;
#(
    parameter  int unsigned WIN   = 8,
    localparam int unsigned CNT_W = cnt_width(WIN)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             accept_i,
    input  logic             data_i,
    input  logic [CNT_W-1:0] th_hi_i,
    input  logic [CNT_W-1:0] th_lo_i,
    output logic [CNT_W-1:0] count_o,
    output logic             vote_o,
    output logic             vote_next_o
);

    logic [WIN-1:0]   hist_q, hist_d;
    logic [CNT_W-1:0] count_q, count_d, count_step;
    logic             vote_q, vote_d, vote_step, oldest;

    always_comb begin
        // History starts zeroed, so the oldest bit reads 0 until the window has filled.
        oldest     = hist_q[WIN-1];
        count_step = count_q + {{(CNT_W-1){1'b0}}, data_i} - {{(CNT_W-1){1'b0}}, oldest};
        vote_step  = vote_q ? !(count_step <= th_lo_i) : (count_step >= th_hi_i);

        hist_d  = hist_q;
        count_d = count_q;
        vote_d  = vote_q;
        if (clear_i) begin
            hist_d  = '0;
            count_d = '0;
            vote_d  = RstVote;
        end else if (accept_i) begin
            hist_d  = {hist_q[WIN-2:0], data_i};
            count_d = count_step;
            vote_d  = vote_step;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hist_q  <= '0;
            count_q <= '0;
            vote_q  <= RstVote;
        end else begin
            hist_q  <= hist_d;
            count_q <= count_d;
            vote_q  <= vote_d;
        end
    end

    assign count_o     = count_q;
    assign vote_o      = vote_q;
    assign vote_next_o = vote_d;

endmodule

// File: rtl/windowed_majority_voter.sv
// Multi-channel sliding-window majority voter with hysteresis, spatial vote and valid/ready.
module windowed_majority_voter
    import majority_pkg::*;
#(
    parameter  int unsigned CH         = 5,
    parameter  int unsigned WIN        = 8,
    parameter  int unsigned SPATIAL_TH = (CH / 2) + 1,
    localparam int unsigned CNT_W      = cnt_width(WIN)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clear_i,
    input  logic [CNT_W-1:0]    th_hi_i,
    input  logic [CNT_W-1:0]    th_lo_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [CH-1:0]       in_data_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [CH-1:0]       vote_o,
    output logic                vote_all_o,
    output logic [CH*CNT_W-1:0] counts_o,
    output logic                win_full_o
);

    logic                      accept;
    logic [CH-1:0]             vote_next;
    logic [CH-1:0][CNT_W-1:0]  count_w;
    logic [CNT_W-1:0]          fill_q, fill_d;
    logic                      win_full_q, win_full_d;
    logic                      out_valid_q, out_valid_d;
    logic                      vote_all_q, vote_all_d;

    always_comb begin
        in_ready_o = clear_i ? ClrInReady : (!out_valid_q || out_ready_i);
        accept     = in_valid_i && in_ready_o;
    end

    for (genvar k = 0; k < CH; k++) begin : g_ch
        majority_window_ch #(
            .WIN(WIN)
        ) u_ch (
            .clk_i      (clk_i),
            .rst_ni     (rst_ni),
            .clear_i    (clear_i),
            .accept_i   (accept),
            .data_i     (in_data_i[k]),
            .th_hi_i    (th_hi_i),
            .th_lo_i    (th_lo_i),
            .count_o    (count_w[k]),
            .vote_o     (vote_o[k]),
            .vote_next_o(vote_next[k])
        );
    end

    always_comb begin
        fill_d      = fill_q;
        out_valid_d = out_valid_q;
        // vote_next already holds when idle and is zero under clear.
        vote_all_d  = popcount(32'(vote_next)) >= SPATIAL_TH;
        if (clear_i) begin
            fill_d      = '0;
            out_valid_d = RstOutValid;
        end else if (accept) begin
            if (fill_q != CNT_W'(WIN)) fill_d = fill_q + 1'b1;
            out_valid_d = 1'b1;
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
        end
        win_full_d = (fill_d == CNT_W'(WIN));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fill_q      <= '0;
            win_full_q  <= RstWinFull;
            out_valid_q <= RstOutValid;
            vote_all_q  <= RstVoteAll;
        end else begin
            fill_q      <= fill_d;
            win_full_q  <= win_full_d;
            out_valid_q <= out_valid_d;
            vote_all_q  <= vote_all_d;
        end
    end

    assign counts_o    = count_w;
    assign out_valid_o = out_valid_q;
    assign vote_all_o  = vote_all_q;
    assign win_full_o  = win_full_q;

endmodule

// File: tb/tb_windowed_majority_voter.sv
// Directed bench for windowed_majority_voter with a queue-based reference model.
module tb_windowed_majority_voter;

    localparam int CH    = 5;
    localparam int WIN   = 8;
    localparam int CNT_W = 4;

    logic                clk = 1'b0;
    logic                rst_n, clear, in_valid, in_ready, out_valid, out_ready;
    logic                vote_all, win_full;
    logic [CNT_W-1:0]    th_hi, th_lo;
    logic [CH-1:0]       in_data, vote;
    logic [CH*CNT_W-1:0] counts;

    int n_checks = 0;
    int n_errors = 0;

    windowed_majority_voter #(
        .CH (CH),
        .WIN(WIN)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .clear_i    (clear),
        .th_hi_i    (th_hi),
        .th_lo_i    (th_lo),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .in_data_i  (in_data),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .vote_o     (vote),
        .vote_all_o (vote_all),
        .counts_o   (counts),
        .win_full_o (win_full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: per-channel queue of the last WIN accepted bits.
    bit            mq[CH][$];
    int            m_cnt[CH];
    logic [CH-1:0] m_vote;
    logic          m_vall, m_ov, m_wf;
    int            m_fill;

    task automatic m_flush();
        for (int k = 0; k < CH; k++) begin
            mq[k].delete();
            m_cnt[k] = 0;
        end
        m_vote = '0;
        m_vall = 1'b0;
        m_ov   = 1'b0;
        m_wf   = 1'b0;
        m_fill = 0;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || clear) begin
            m_flush();
        end else if (in_valid && (!m_ov || out_ready)) begin
            int nv;
            nv = 0;
            for (int k = 0; k < CH; k++) begin
                mq[k].push_back(in_data[k]);
                if (mq[k].size() > WIN) void'(mq[k].pop_front());
                m_cnt[k] = 0;
                foreach (mq[k][i]) m_cnt[k] += int'(mq[k][i]);
                if (!m_vote[k] && m_cnt[k] >= int'(th_hi)) m_vote[k] = 1'b1;
                else if (m_vote[k] && m_cnt[k] <= int'(th_lo)) m_vote[k] = 1'b0;
                nv += int'(m_vote[k]);
            end
            m_vall = (nv >= CH / 2 + 1);
            m_fill++;
            m_wf = (m_fill >= WIN);
            m_ov = 1'b1;
        end else if (out_ready) begin
            m_ov = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            logic [CH*CNT_W-1:0] exp_counts;
            for (int k = 0; k < CH; k++) exp_counts[k*CNT_W +: CNT_W] = m_cnt[k][CNT_W-1:0];
            chk("model_in_ready", in_ready, !clear && (!m_ov || out_ready));
            chk("model_out_valid", out_valid, m_ov);
            chk("model_vote", vote, m_vote);
            chk("model_vote_all", vote_all, m_vall);
            chk("model_counts", counts, exp_counts);
            chk("model_win_full", win_full, m_wf);
        end
    end

    task automatic step(input logic v, input logic [CH-1:0] d);
        in_valid = v;
        in_data  = d;
        @(posedge clk);
        #2;
    endtask

    task automatic do_clear();
        clear    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        clear = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        th_hi     = 4'd5;
        th_lo     = 4'd2;
        #3;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;

        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 5'b11111);
            chk("fill_cnt0", counts[3:0], i);
            chk("fill_cnt4", counts[19:16], i);
            chk("fill_vote", vote, (i >= 5) ? 5'b11111 : 5'b00000);
            chk("fill_vote_all", vote_all, i >= 5);
            chk("fill_win_full", win_full, i == 8);
            chk("fill_out_valid", out_valid, 1);
        end

        for (int j = 1; j <= 6; j++) begin
            step(1'b1, 5'b00000);
            chk("slide_cnt2", counts[11:8], 8 - j);
            chk("slide_vote", vote, (8 - j > 2) ? 5'b11111 : 5'b00000);
            chk("slide_vote_all", vote_all, 8 - j > 2);
        end

        out_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            step(1'b1, 5'b11111);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_cnt0", counts[3:0], 2);
            chk("stall_out_valid", out_valid, 1);
        end
        out_ready = 1'b1;
        step(1'b1, 5'b11111);
        chk("release_cnt_a", counts[3:0], 2);
        step(1'b1, 5'b11111);
        chk("release_cnt_b", counts[3:0], 2);
        step(1'b1, 5'b11111);
        chk("release_cnt_c", counts[3:0], 3);

        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 5'b11111;
        #1;
        chk("clear_in_ready", in_ready, 0);
        @(posedge clk);
        #2;
        chk("clear_counts", counts, 0);
        chk("clear_vote", vote, 0);
        chk("clear_win_full", win_full, 0);
        chk("clear_out_valid", out_valid, 0);
        clear = 1'b0;
        step(1'b1, 5'b00001);
        chk("post_clear_cnt0", counts[3:0], 1);
        chk("post_clear_cnt1", counts[7:4], 0);

        do_clear();
        th_hi = 4'd9;
        for (int i = 0; i < 8; i++) step(1'b1, 5'b11111);
        chk("th9_vote", vote, 0);
        chk("th9_cnt0", counts[3:0], 8);
        chk("th9_win_full", win_full, 1);

        do_clear();
        th_hi = 4'd0;
        th_lo = 4'd0;
        step(1'b1, 5'b00000);
        chk("th0_vote", vote, 5'b11111);
        chk("th0_vote_all", vote_all, 1);

        do_clear();
        th_hi = 4'd1;
        step(1'b1, 5'b00111);
        chk("spatial3_vote", vote, 5'b00111);
        chk("spatial3_vote_all", vote_all, 1);
        do_clear();
        step(1'b1, 5'b00011);
        chk("spatial2_vote", vote, 5'b00011);
        chk("spatial2_vote_all", vote_all, 0);

        do_clear();
        th_hi = 4'd4;
        th_lo = 4'd2;
        for (int i = 0; i < 80; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            clear     = ($urandom_range(0, 24) == 0);
            if (i == 40) begin
                th_hi = 4'd6;
                th_lo = 4'd5;
            end
            step($urandom_range(0, 3) != 0, CH'($urandom));
        end
        clear     = 1'b0;
        out_ready = 1'b1;

        for (int i = 0; i < 4; i++) step(1'b1, 5'b10101);
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", out_valid, 0);
        chk("async_rst_in_ready", in_ready, 1);
        chk("async_rst_counts", counts, 0);
        chk("async_rst_vote", vote, 0);
        chk("async_rst_vote_all", vote_all, 0);
        chk("async_rst_win_full", win_full, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        step(1'b1, 5'b11111);
        chk("after_rst_cnt0", counts[3:0], 1);
        step(1'b0, 5'b00000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
